// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings, default latencies.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mdu_ctrl_pkg;

    // Default busy lengths, in cycles after the capturing edge.
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // The busy counter is 4 bits, so the usable latency range is 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_MADD  = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    // Map a latency parameter onto the counter load value, clamped to 1..15 so an
    // out-of-range parameter can never produce a zero-length or wrapped operation.
    function automatic logic [CNT_W-1:0] cyc_to_cnt(input int cyc);
        if (cyc < 1) begin
            return CNT_W'(1);
        end else if (cyc > 15) begin
            return CNT_W'(15);
        end else begin
            return CNT_W'(cyc);
        end
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between the E-stage and the multiply/divide unit.
// Latency: n/a (wires only).
// Backpressure: none on the bus itself; the issuer must watch Busy.
interface mdu_ctrl_if;

    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] Data1;
    logic [31:0] Data2;
    logic        Busy;
    logic        Done;
    logic [31:0] HI;
    logic [31:0] LO;

    // Pipeline side issues operations and reads HI/LO.
    modport master (
        output Start, MDOp, Data1, Data2,
        input  Busy, Done, HI, LO
    );

    // Multiply/divide unit side.
    modport slave (
        input  Start, MDOp, Data1, Data2,
        output Busy, Done, HI, LO
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational mult/multu/div/divu/madd datapath producing a 64-bit {HI,LO} image.
// Latency: 0 cycles (pure combinational); the caller registers the result.
// Backpressure: none.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_safe;
    logic               div_ovf;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    assign prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u   = {32'd0, a} * {32'd0, b};
    assign div_zero = (b == 32'd0);

    // -2^31 / -1 overflows; dividing by 1 instead yields the wrapped quotient
    // (0x80000000) and a zero remainder, and a zero divisor is likewise
    // replaced so the dividers never see a trap-worthy operand.
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign b_safe   = (div_zero || div_ovf) ? 32'd1 : b;

    // Truncating division: the remainder carries the dividend's sign.
    assign quo_s    = $signed(a) / $signed(b_safe);
    assign rem_s    = $signed(a) % $signed(b_safe);
    assign quo_u    = a / b_safe;
    assign rem_u    = a % b_safe;

    // Select the {HI,LO} image for the requested operation.
    always_comb begin
        result = 64'd0;
        case (op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {rem_s, quo_s};
            OP_DIVU:  result = {rem_u, quo_u};
            OP_MADD:  result = {hi, lo} + prod_s;
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit control: FSM, busy counter and architectural HI/LO (madd gated by MDU_MADD_EN).
// Latency: MULT_CYC cycles for mult/multu/madd, DIV_CYC for div/divu; mthi/mtlo write HI/LO at the issue edge.
// Backpressure: Busy high while in flight; any Start seen while Busy is dropped (hazard unit stalls instead).
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    mdu_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] MULT_CNT = cyc_to_cnt(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_CNT  = cyc_to_cnt(DIV_CYC);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;
    logic             done_q,  done_d;
    logic [63:0]      res_q,   res_d;
    logic             dz_q,    dz_d;

    mdu_op_e          op;
    logic             is_mult;
    logic             is_div;
    logic [63:0]      arith_res;
    logic             arith_dz;

    assign op = mdu_op_e'(bus.MDOp);

`ifdef MDU_MADD_EN
    assign is_mult = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
`else
    // madd falls through as a no-op when the accumulate feature is not built.
    assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
`endif
    assign is_div  = (op == OP_DIV) || (op == OP_DIVU);

    // The result is computed from the operands (and current HI/LO for madd)
    // present at the capture edge and parked in res_q until commit.
    mdu_arith u_arith (
        .op       (op),
        .a        (bus.Data1),
        .b        (bus.Data2),
        .hi       (hi_q),
        .lo       (lo_q),
        .result   (arith_res),
        .div_zero (arith_dz)
    );

    // Next-state: capture or move-to in IDLE, count down while busy, commit on the last busy edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        res_d   = res_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    if (is_mult) begin
                        state_d = ST_MULT;
                        cnt_d   = MULT_CNT;
                        res_d   = arith_res;
                        dz_d    = 1'b0;
                    end else if (is_div) begin
                        state_d = ST_DIV;
                        cnt_d   = DIV_CNT;
                        res_d   = arith_res;
                        dz_d    = arith_dz;
                    end else if (op == OP_MTHI) begin
                        hi_d = bus.Data1;
                    end else if (op == OP_MTLO) begin
                        lo_d = bus.Data1;
                    end
                end
            end
            ST_MULT, ST_DIV: begin
                // Start is deliberately not looked at here: issue while busy is dropped.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    // A zero divisor still runs the full latency and pulses Done,
                    // but leaves HI/LO as they were.
                    if (!dz_q) begin
                        {hi_d, lo_d} = res_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, HI/LO and pending-result registers; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
            res_q   <= 64'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
        end
    end

    // Busy decodes straight from the state register, so Start never reaches it combinationally.
    assign bus.Busy = (state_q != ST_IDLE);
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vectors plus randomized ops against an arithmetic model.
// Latency: checks MULT_CYC/DIV_CYC busy lengths and the Done position relative to Busy falling.
// Backpressure: exercises Start while Busy (must be ignored) and mid-operation reset.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MC  = 5;
    localparam int DC  = 10;
    localparam int WIN = 16;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    // Reference model: applies one issued op to the architectural HI/LO and
    // reports how many busy cycles and Done pulses it should cause.
    task automatic model_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int eb, output int ed);
        longint sa, sb, ps, qm, q, r;
        logic [63:0] acc;
        eb = 0;
        ed = 0;
        if (!st) return;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ps = sa * sb;
        case (op)
            3'd1: begin {m_hi, m_lo} = 64'(ps); eb = MC; ed = 1; end
            3'd2: begin acc = 64'(a) * 64'(b); {m_hi, m_lo} = acc; eb = MC; ed = 1; end
            3'd3: begin
                eb = DC; ed = 1;
                if (b != 0) begin
                    qm = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                    q  = ((sa < 0) != (sb < 0)) ? -qm : qm;
                    r  = sa - q * sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd4: begin
                eb = DC; ed = 1;
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a - (a / b) * b;
                end
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            3'd7: begin
`ifdef MDU_MADD_EN
                acc = {m_hi, m_lo} + 64'(ps);
                {m_hi, m_lo} = acc;
                eb = MC; ed = 1;
`endif
            end
            default: ;
        endcase
    endtask

    // Issue one op for a single cycle, then observe a fixed window: count busy
    // cycles and Done pulses, note where Done fell and whether HI/LO moved while busy.
    task automatic drive_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, output int bc, output int dc,
                            output int di, output int mv);
        logic [31:0] h0, l0;
        @(negedge Clk);
        bus.Start = st; bus.MDOp = op; bus.Data1 = a; bus.Data2 = b;
        @(negedge Clk);
        bus.Start = 1'b0; bus.MDOp = 3'($urandom_range(0, 7));
        bus.Data1 = $urandom; bus.Data2 = $urandom;
        h0 = bus.HI; l0 = bus.LO;
        bc = 0; dc = 0; di = -1; mv = 0;
        for (int i = 0; i < WIN; i++) begin
            if (bus.Busy === 1'b1) begin
                bc++;
                if (bus.HI !== h0 || bus.LO !== l0) mv++;
            end
            if (bus.Done === 1'b1) begin
                dc++;
                if (di < 0) di = i;
            end
            @(negedge Clk);
        end
        bus.MDOp = 3'd0;
    endtask

    task automatic test_reset();
        bus.Start = 1'b0; bus.MDOp = 3'd0; bus.Data1 = 32'd0; bus.Data2 = 32'd0;
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
        n_cmp++; if (bus.Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.Done); end
        n_cmp++; if (bus.HI !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", bus.HI); end
        n_cmp++; if (bus.LO !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", bus.LO); end
        Reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult();
        int eb, ed, bc, dc, di, mv;
        model_op(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd7, eb, ed);
        drive_op(1'b1, 3'd1, 32'hFFFF_FFFD, 32'd7, bc, dc, di, mv);
        n_cmp++; if (bc !== 5) begin n_err++; $display("FAIL mult_busy: got %0d want 5", bc); end
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL mult_done_cnt: got %0d want 1", dc); end
        n_cmp++; if (di !== 5) begin n_err++; $display("FAIL mult_done_pos: got %0d want 5", di); end
        n_cmp++; if (mv !== 0) begin n_err++; $display("FAIL mult_hilo_stable: got %0d moves want 0", mv); end
        n_cmp++; if (bus.HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", bus.HI); end
        n_cmp++; if (bus.LO !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo: got %h want ffffffeb", bus.LO); end
        drive_op(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, bc, dc, di, mv);
        model_op(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, eb, ed);
        n_cmp++; if ({bus.HI, bus.LO} !== {m_hi, m_lo}) begin n_err++; $display("FAIL multu_res: got %h%h want %h%h", bus.HI, bus.LO, m_hi, m_lo); end
    endtask

    task automatic test_div();
        int eb, ed, bc, dc, di, mv;
        drive_op(1'b1, 3'd4, 32'd100, 32'd7, bc, dc, di, mv);
        model_op(1'b1, 3'd4, 32'd100, 32'd7, eb, ed);
        n_cmp++; if (bc !== 10) begin n_err++; $display("FAIL divu_busy: got %0d want 10", bc); end
        n_cmp++; if (di !== 10) begin n_err++; $display("FAIL divu_done_pos: got %0d want 10", di); end
        n_cmp++; if (bus.LO !== 32'd14) begin n_err++; $display("FAIL divu_lo: got %0d want 14", bus.LO); end
        n_cmp++; if (bus.HI !== 32'd2) begin n_err++; $display("FAIL divu_hi: got %0d want 2", bus.HI); end
        drive_op(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, bc, dc, di, mv);
        model_op(1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, eb, ed);
        n_cmp++; if (bus.LO !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", bus.LO); end
        n_cmp++; if (bus.HI !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", bus.HI); end
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL div_done_cnt: got %0d want 1", dc); end
    endtask

    task automatic test_div_zero();
        int eb, ed, bc, dc, di, mv;
        drive_op(1'b1, 3'd5, 32'd5, 32'd0, bc, dc, di, mv);
        drive_op(1'b1, 3'd6, 32'd6, 32'd0, bc, dc, di, mv);
        model_op(1'b1, 3'd5, 32'd5, 32'd0, eb, ed);
        model_op(1'b1, 3'd6, 32'd6, 32'd0, eb, ed);
        drive_op(1'b1, 3'd3, 32'h1234_5678, 32'd0, bc, dc, di, mv);
        n_cmp++; if (bc !== 10) begin n_err++; $display("FAIL divz_busy: got %0d want 10", bc); end
        n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL divz_done: got %0d want 1", dc); end
        n_cmp++; if (bus.HI !== 32'd5) begin n_err++; $display("FAIL divz_hi: got %h want 5", bus.HI); end
        n_cmp++; if (bus.LO !== 32'd6) begin n_err++; $display("FAIL divz_lo: got %h want 6", bus.LO); end
    endtask

    task automatic test_mthi_mtlo();
        int busy_seen = 0;
        int done_seen = 0;
        @(negedge Clk);
        bus.Start = 1'b1; bus.MDOp = 3'd5; bus.Data1 = 32'h1234;
        @(negedge Clk);
        if (bus.Busy !== 1'b0) busy_seen++;
        if (bus.Done !== 1'b0) done_seen++;
        bus.MDOp = 3'd6; bus.Data1 = 32'h5678;
        @(negedge Clk);
        bus.Start = 1'b0; bus.MDOp = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.Busy !== 1'b0) busy_seen++;
            if (bus.Done !== 1'b0) done_seen++;
            @(negedge Clk);
        end
        m_hi = 32'h1234; m_lo = 32'h5678;
        n_cmp++; if (bus.HI !== 32'h1234) begin n_err++; $display("FAIL mthi_val: got %h want 1234", bus.HI); end
        n_cmp++; if (bus.LO !== 32'h5678) begin n_err++; $display("FAIL mtlo_val: got %h want 5678", bus.LO); end
        n_cmp++; if (busy_seen !== 0) begin n_err++; $display("FAIL mtx_busy: got %0d busy samples want 0", busy_seen); end
        n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL mtx_done: got %0d done samples want 0", done_seen); end
    endtask

    task automatic test_busy_ignore();
        int eb, ed, bc;
        model_op(1'b1, 3'd1, 32'd1000, 32'd3000, eb, ed);
        @(negedge Clk);
        bus.Start = 1'b1; bus.MDOp = 3'd1; bus.Data1 = 32'd1000; bus.Data2 = 32'd3000;
        @(negedge Clk);                          // busy cycle 1
        bus.Start = 1'b0; bus.MDOp = 3'd0;
        @(negedge Clk);                          // busy cycle 2: try to sneak in mthi
        bus.Start = 1'b1; bus.MDOp = 3'd5; bus.Data1 = 32'hDEAD_BEEF;
        @(negedge Clk);
        bus.Start = 1'b0; bus.MDOp = 3'd0;
        bc = 0;
        while (bus.Busy === 1'b1 && bc < WIN) begin
            bc++;
            @(negedge Clk);
        end
        n_cmp++; if (bc >= WIN) begin n_err++; $display("FAIL ign_timeout: busy still high after %0d cycles", bc); end
        n_cmp++; if (bus.HI !== m_hi) begin n_err++; $display("FAIL ign_hi: got %h want %h", bus.HI, m_hi); end
        n_cmp++; if (bus.LO !== m_lo) begin n_err++; $display("FAIL ign_lo: got %h want %h", bus.LO, m_lo); end
    endtask

    task automatic test_reset_mid();
        int bc, dc;
        @(negedge Clk);
        bus.Start = 1'b1; bus.MDOp = 3'd4; bus.Data1 = 32'd99; bus.Data2 = 32'd4;
        @(negedge Clk);                          // busy cycle 1
        bus.Start = 1'b0; bus.MDOp = 3'd0;
        @(negedge Clk);                          // busy cycle 2
        @(negedge Clk);                          // busy cycle 3
        n_cmp++; if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre_busy: got %b want 1", bus.Busy); end
        Reset = 1'b0;
        #1;
        n_cmp++; if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", bus.Busy); end
        n_cmp++; if ({bus.HI, bus.LO} !== 64'd0) begin n_err++; $display("FAIL rmid_hilo: got %h%h want 0", bus.HI, bus.LO); end
        @(negedge Clk);
        Reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        bc = 0; dc = 0;
        for (int i = 0; i < WIN; i++) begin
            if (bus.Busy === 1'b1) bc++;
            if (bus.Done === 1'b1) dc++;
            @(negedge Clk);
        end
        n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL rmid_done: got %0d pulses want 0", dc); end
        n_cmp++; if (bc !== 0) begin n_err++; $display("FAIL rmid_busy_after: got %0d want 0", bc); end
        n_cmp++; if ({bus.HI, bus.LO} !== 64'd0) begin n_err++; $display("FAIL rmid_hilo_after: got %h%h want 0", bus.HI, bus.LO); end
    endtask

    task automatic test_madd();
        int eb, ed, bc, dc, di, mv;
        logic [31:0] want_hi, want_lo;
        int want_bc;
        drive_op(1'b1, 3'd5, 32'd0, 32'd0, bc, dc, di, mv);
        drive_op(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd0, bc, dc, di, mv);
        model_op(1'b1, 3'd5, 32'd0, 32'd0, eb, ed);
        model_op(1'b1, 3'd6, 32'hFFFF_FFFF, 32'd0, eb, ed);
        drive_op(1'b1, 3'd7, 32'd1, 32'd1, bc, dc, di, mv);
        model_op(1'b1, 3'd7, 32'd1, 32'd1, eb, ed);
`ifdef MDU_MADD_EN
        want_hi = 32'd1; want_lo = 32'd0; want_bc = MC;
`else
        want_hi = 32'd0; want_lo = 32'hFFFF_FFFF; want_bc = 0;
`endif
        n_cmp++; if (bus.HI !== want_hi) begin n_err++; $display("FAIL madd_hi: got %h want %h", bus.HI, want_hi); end
        n_cmp++; if (bus.LO !== want_lo) begin n_err++; $display("FAIL madd_lo: got %h want %h", bus.LO, want_lo); end
        n_cmp++; if (bc !== want_bc) begin n_err++; $display("FAIL madd_busy: got %0d want %0d", bc, want_bc); end
    endtask

    task automatic test_random();
        int eb, ed, bc, dc, di, mv;
        logic        st;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int n = 0; n < 150; n++) begin
            st = ($urandom_range(0, 9) != 0);
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            drive_op(st, op, a, b, bc, dc, di, mv);
            model_op(st, op, a, b, eb, ed);
            n_cmp++; if (bc !== eb) begin n_err++; $display("FAIL rnd_busy[%0d] op=%0d st=%b: got %0d want %0d", n, op, st, bc, eb); end
            n_cmp++; if (dc !== ed) begin n_err++; $display("FAIL rnd_done[%0d] op=%0d: got %0d want %0d", n, op, dc, ed); end
            n_cmp++; if (ed == 1 && di !== eb) begin n_err++; $display("FAIL rnd_done_pos[%0d]: got %0d want %0d", n, di, eb); end
            n_cmp++; if (mv !== 0) begin n_err++; $display("FAIL rnd_stable[%0d]: got %0d moves want 0", n, mv); end
            n_cmp++; if (bus.HI !== m_hi) begin n_err++; $display("FAIL rnd_hi[%0d] op=%0d a=%h b=%h: got %h want %h", n, op, a, b, bus.HI, m_hi); end
            n_cmp++; if (bus.LO !== m_lo) begin n_err++; $display("FAIL rnd_lo[%0d] op=%0d a=%h b=%h: got %h want %h", n, op, a, b, bus.LO, m_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_busy_ignore();
        test_reset_mid();
        test_madd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
